// File: rtl/mem_bus_arbiter_if.sv
// Request/completion bus shared by both masters and the slave of the memory arbiter.
// The master drives the request fields, and the slave drives the completion fields.
interface mem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          we;
  logic          start;
  logic [DW-1:0] q;
  logic          done;

  modport master (output addr, data, we, start, input q, done);
  modport slave  (input addr, data, we, start, output q, done);
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master (data D, instruction I) to one-slave memory bus arbiter.
// D has fixed priority, and a consecutive-grant counter keeps I from starving.
module mem_bus_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_CONSEC = 4
) (
  input  logic                clk,
  input  logic                nreset,
  mem_bus_arbiter_if.slave    d_bus,
  mem_bus_arbiter_if.slave    i_bus,
  mem_bus_arbiter_if.master   s_bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_D = 2'b01,
    BUSY_I = 2'b10
  } state_t;

  localparam int            CW   = (MAX_CONSEC < 1) ? 1 : $clog2(MAX_CONSEC + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_CONSEC);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] consec;
  logic          grant_d;
  logic          grant_i;
  logic          i_starved;

  logic [AW-1:0] s_addr_r;
  logic [DW-1:0] s_data_r;
  logic          s_we_r;
  logic          s_start_r;

  // I is a read-only master, so its write fields are never looked at.
  logic          unused_i_fields;
  assign unused_i_fields = ^{i_bus.data, i_bus.we};

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CMAX) ? CMAX : c + CW'(1);
  endfunction

  assign i_starved = i_bus.start && (consec == CMAX);

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    case (state)
      IDLE: begin
        if (d_bus.start && !i_starved) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (i_bus.start) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_D, BUSY_I: begin
        if (s_bus.done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant edge: the winner's request is latched, and it then stays stable for the slave.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      consec    <= '0;
      s_addr_r  <= '0;
      s_data_r  <= '0;
      s_we_r    <= 1'b0;
      s_start_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_d) begin
        s_addr_r  <= d_bus.addr;
        s_data_r  <= d_bus.data;
        s_we_r    <= d_bus.we;
        s_start_r <= 1'b1;
        consec    <= i_bus.start ? sat_inc(consec) : '0;
      end else if (grant_i) begin
        s_addr_r  <= i_bus.addr;
        s_data_r  <= '0;
        s_we_r    <= 1'b0;
        s_start_r <= 1'b1;
        consec    <= '0;
      end else if ((state != IDLE) && s_bus.done) begin
        s_start_r <= 1'b0;
        s_we_r    <= 1'b0;
      end
    end
  end

  assign s_bus.addr  = s_addr_r;
  assign s_bus.data  = s_data_r;
  assign s_bus.we    = s_we_r;
  assign s_bus.start = s_start_r;

  // Completion is routed combinationally in the s_done cycle, and q is zeroed otherwise.
  assign d_bus.done = (state == BUSY_D) && s_bus.done;
  assign i_bus.done = (state == BUSY_I) && s_bus.done;
  assign d_bus.q    = d_bus.done ? s_bus.q : '0;
  assign i_bus.q    = i_bus.done ? s_bus.q : '0;

endmodule
